eth_tx_framer: RTL

//  Transmit-side framer; the opposite direction of the eth_rx path. Takes frame bytes
//  (DA..payload) from a sys_clk-domain source and emits the 9-bit {in_frame, byte}

---
 rtl/eth_tx_framer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_framer.sv
// Transmit framer: preamble/SFD, payload, optional zero-pad, CRC-32 FCS and IFG
// emitted as a 9-bit {in_frame, byte} stream. Define ETH_TX_PAD_EN to enable padding.
module eth_tx_framer #(
  parameter int unsigned P_PREAMBLE  = 7,
  parameter int unsigned P_MIN_FRAME = 60,
  parameter int unsigned P_IFG_BYTES = 12,
  parameter int unsigned P_CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_vld,
  output logic       s_rdy,
  output logic [8:0] data_out,
  output logic       data_out_vld,
  input  logic       data_out_rdy,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
`ifdef ETH_TX_PAD_EN
    PAD  = 3'd3,
`endif
    FCS  = 3'd4,
    IFG  = 3'd5
  } state_t;

  localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [P_CNT_W-1:0] PRE_LAST = P_CNT_W'(P_PREAMBLE);
  localparam logic [P_CNT_W-1:0] IFG_LAST = P_CNT_W'(P_IFG_BYTES - 1);

  state_t               state, state_nxt;
  logic [P_CNT_W-1:0]   idx, idx_nxt;
  logic [P_CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [31:0]          crc, crc_nxt, fcs;
  logic [8:0]           out_nxt;
  logic                 vld_nxt;
  logic                 fcs_last, fcs_last_nxt;
  logic                 load;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    b = d;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r[0] ^ b[0]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      b = b >> 1;
    end
    return r;
  endfunction

  assign load    = !data_out_vld || data_out_rdy;
  assign busy    = (state != IDLE);
  assign fcs     = ~crc;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    crc_nxt      = crc;
    out_nxt      = data_out;
    vld_nxt      = data_out_vld;
    fcs_last_nxt = fcs_last;
    s_rdy        = 1'b0;
    // A loading output stage with nothing new to say carries a bubble.
    if (load) begin
      out_nxt      = '0;
      vld_nxt      = 1'b0;
      fcs_last_nxt = 1'b0;
    end
    case (state)
      IDLE: begin
        if (s_vld) begin
          state_nxt = PRE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          crc_nxt   = '1;
        end
      end
      PRE: begin
        if (load) begin
          vld_nxt = 1'b1;
          if (idx == PRE_LAST) begin
            out_nxt   = {1'b1, 8'hD5};
            idx_nxt   = '0;
            state_nxt = DATA;
          end else begin
            out_nxt = {1'b1, 8'h55};
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DATA: begin
        s_rdy = load;
        if (load && s_vld) begin
          vld_nxt = 1'b1;
          out_nxt = {1'b1, s_data};
          crc_nxt = crc_byte(crc, s_data);
          cnt_nxt = cnt_inc;
          if (s_last) begin
            idx_nxt = '0;
`ifdef ETH_TX_PAD_EN
            state_nxt = ((32'(cnt) + 32'd1) < P_MIN_FRAME) ? PAD : FCS;
`else
            state_nxt = FCS;
`endif
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        if (load) begin
          vld_nxt = 1'b1;
          out_nxt = {1'b1, 8'h00};
          crc_nxt = crc_byte(crc, 8'h00);
          cnt_nxt = cnt_inc;
          if ((32'(cnt) + 32'd1) >= P_MIN_FRAME) begin
            idx_nxt   = '0;
            state_nxt = FCS;
          end
        end
      end
`endif
      FCS: begin
        if (load) begin
          vld_nxt = 1'b1;
          case (idx[1:0])
            2'd0:    out_nxt = {1'b1, fcs[7:0]};
            2'd1:    out_nxt = {1'b1, fcs[15:8]};
            2'd2:    out_nxt = {1'b1, fcs[23:16]};
            default: out_nxt = {1'b1, fcs[31:24]};
          endcase
          if (idx[1:0] == 2'd3) begin
            fcs_last_nxt = 1'b1;
            idx_nxt      = '0;
            state_nxt    = IFG;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      IFG: begin
        if (load) begin
          vld_nxt = 1'b1;
          out_nxt = '0;
          if (idx == IFG_LAST) begin
            idx_nxt = '0;
            // A waiting frame skips IDLE so its preamble follows the last gap byte.
            if (s_vld) begin
              state_nxt = PRE;
              cnt_nxt   = '0;
              crc_nxt   = '1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      crc          <= '1;
      data_out     <= '0;
      data_out_vld <= 1'b0;
      fcs_last     <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      crc          <= crc_nxt;
      data_out     <= out_nxt;
      data_out_vld <= vld_nxt;
      fcs_last     <= fcs_last_nxt;
      tx_done      <= data_out_vld && data_out_rdy && fcs_last;
    end
  end

endmodule
